// File: rtl/whack_if.sv
// Port bundle between the button front-end and the whack-a-mole round controller.
// The front-end (master) drives start/btn; the controller (slave) drives everything else.
interface whack_if #(
  parameter int NUM_MOLES = 4,
  parameter int SCORE_W   = 8
);
  // No valid/ready pairs here: start and btn are single-cycle pulses, taken on the edge they are high,
  // and every output is a registered level except hit, a one-cycle pulse per scored hit.
  logic                 start;
  logic [NUM_MOLES-1:0] btn;
  logic [NUM_MOLES-1:0] mole;
  logic [5:0]           time_left;
  logic [SCORE_W-1:0]   score;
  logic                 playing;
  logic                 game_over;
  logic                 hit;
  logic [1:0]           state_dbg;

  modport master (
    output start, btn,
    input  mole, time_left, score, playing, game_over, hit, state_dbg
  );

  modport slave (
    input  start, btn,
    output mole, time_left, score, playing, game_over, hit, state_dbg
  );
endinterface

// File: rtl/whack_game_ctrl.sv
// One whack-a-mole round: start, seconds countdown, pseudo-random moles, hit scoring, game over.
// Optional MISS_PENALTY_EN: wrong presses while a mole is up cost one point (saturating at 0).
module whack_game_ctrl #(
  parameter int         NUM_MOLES    = 4,
  parameter int         CLKS_PER_SEC = 50000000,
  parameter int         GAME_SECS    = 60,
  parameter int         MOLE_CYCLES  = 25000000,
  parameter int         GAP_CYCLES   = 10000000,
  parameter int         SCORE_W      = 8,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input logic   clk,
  input logic   reset,
  whack_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_MOLES);
  localparam int PS_W   = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam int PH_MAX = (MOLE_CYCLES > GAP_CYCLES) ? MOLE_CYCLES : GAP_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [1:0] {IDLE, GAP, SHOW, OVER} state_t;

  state_t               state;
  logic [7:0]           lfsr;
  logic [PS_W-1:0]      presc;
  logic [PH_W-1:0]      phase;
  logic [IDX_W-1:0]     prev_idx;
  logic                 prev_valid;
  logic [NUM_MOLES-1:0] mole_r;
  logic [5:0]           time_r;
  logic [SCORE_W-1:0]   score_r;
  logic                 hit_r;

  logic                 correct;
  logic                 tick;
  logic                 last_tick;
  logic [IDX_W-1:0]     raw_idx;
  logic [IDX_W-1:0]     pick_idx;
  logic [SCORE_W-1:0]   score_up;

  assign correct   = (state == SHOW) && |(bus.btn & mole_r);
  assign tick      = ((state == GAP) || (state == SHOW)) && (presc == PS_W'(CLKS_PER_SEC - 1));
  assign last_tick = tick && (time_r == 6'd1);
  assign raw_idx   = lfsr[IDX_W-1:0];
  // Never repeat the previous mole within a round; the +1 wraps because NUM_MOLES is a power of two.
  assign pick_idx  = (prev_valid && (raw_idx == prev_idx)) ? raw_idx + IDX_W'(1) : raw_idx;
  assign score_up  = (&score_r) ? score_r : score_r + SCORE_W'(1);

`ifdef MISS_PENALTY_EN
  logic wrong;
  assign wrong = (state == SHOW) && |(bus.btn & ~mole_r);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lfsr       <= LFSR_SEED;
      presc      <= '0;
      phase      <= '0;
      prev_idx   <= '0;
      prev_valid <= 1'b0;
      mole_r     <= '0;
      time_r     <= '0;
      score_r    <= '0;
      hit_r      <= 1'b0;
    end else begin
      lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      hit_r <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (bus.start) begin
            state      <= GAP;
            time_r     <= 6'(GAME_SECS);
            score_r    <= '0;
            presc      <= '0;
            phase      <= '0;
            prev_valid <= 1'b0;
            mole_r     <= '0;
          end
        end
        default: begin
          presc <= tick ? '0 : presc + PS_W'(1);
          if (tick) time_r <= time_r - 6'd1;
          if (correct) begin
            score_r <= score_up;
            hit_r   <= 1'b1;
          end
`ifdef MISS_PENALTY_EN
          else if (wrong && (score_r != '0)) begin
            score_r <= score_r - SCORE_W'(1);
          end
`endif
          // The final tick ends the round from either phase; a hit on that edge was scored above.
          if (last_tick) begin
            state  <= OVER;
            mole_r <= '0;
          end else if (state == GAP) begin
            if (phase == PH_W'(GAP_CYCLES - 1)) begin
              state      <= SHOW;
              mole_r     <= NUM_MOLES'(1) << pick_idx;
              prev_idx   <= pick_idx;
              prev_valid <= 1'b1;
              phase      <= '0;
            end else begin
              phase <= phase + PH_W'(1);
            end
          end else begin
            if (correct || (phase == PH_W'(MOLE_CYCLES - 1))) begin
              state  <= GAP;
              mole_r <= '0;
              phase  <= '0;
            end else begin
              phase <= phase + PH_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.mole      = mole_r;
  assign bus.time_left = time_r;
  assign bus.score     = score_r;
  assign bus.hit       = hit_r;
  assign bus.playing   = (state == GAP) || (state == SHOW);
  assign bus.game_over = (state == OVER);
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_whack_game_ctrl.sv
// Bench for whack_game_ctrl: round-level reference model compared every cycle, plus directed literal checks.
module tb_whack_game_ctrl;
  localparam int N     = 4;
  localparam int CPS   = 10;
  localparam int SECS  = 3;
  localparam int MOLEC = 5;
  localparam int GAPC  = 2;
  localparam int SW    = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc_no;

  whack_if #(.NUM_MOLES(N), .SCORE_W(SW)) bus ();

  whack_game_ctrl #(
    .NUM_MOLES(N), .CLKS_PER_SEC(CPS), .GAME_SECS(SECS), .MOLE_CYCLES(MOLEC),
    .GAP_CYCLES(GAPC), .SCORE_W(SW), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (round-level) ----------------
  logic [7:0]    m_lfsr;
  logic [N-1:0]  m_mole;
  logic [5:0]    m_time;
  logic [SW-1:0] m_score;
  logic          m_hit;
  logic          m_playing;
  logic          m_over;
  logic          m_in_show;
  logic          m_have_prev;
  int            m_prev;
  int            m_elapsed;
  int            m_win;

  task automatic model_reset();
    m_lfsr = 8'hA5; m_mole = '0; m_time = '0; m_score = '0; m_hit = 1'b0;
    m_playing = 1'b0; m_over = 1'b0; m_in_show = 1'b0; m_have_prev = 1'b0;
    m_prev = 0; m_elapsed = 0; m_win = 0;
  endtask

  task automatic model_step(input logic st, input logic [N-1:0] b);
    int idx;
    logic hit_now;
    m_hit = 1'b0;
    if (!m_playing) begin
      if (st) begin
        m_playing = 1'b1; m_over = 1'b0; m_time = 6'(SECS); m_score = '0;
        m_elapsed = 0; m_win = 0; m_in_show = 1'b0; m_mole = '0; m_have_prev = 1'b0;
      end
    end else begin
      m_elapsed++;
      m_time  = 6'(SECS - m_elapsed / CPS);
      hit_now = m_in_show && ((b & m_mole) != 0);
      if (hit_now) begin
        m_hit = 1'b1;
        if (m_score != {SW{1'b1}}) m_score = m_score + 1'b1;
      end
`ifdef MISS_PENALTY_EN
      else if (m_in_show && ((b & ~m_mole) != 0) && m_score != 0) m_score = m_score - 1'b1;
`endif
      if (m_elapsed == SECS * CPS) begin
        m_playing = 1'b0; m_over = 1'b1; m_mole = '0; m_in_show = 1'b0;
      end else begin
        m_win++;
        if (!m_in_show && m_win == GAPC) begin
          idx = int'(m_lfsr) % N;
          if (m_have_prev && idx == m_prev) idx = (idx + 1) % N;
          m_mole = N'(1) << idx; m_prev = idx; m_have_prev = 1'b1;
          m_in_show = 1'b1; m_win = 0;
        end else if (m_in_show && (hit_now || m_win == MOLEC)) begin
          m_mole = '0; m_in_show = 1'b0; m_win = 0;
        end
      end
    end
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_step(bus.start, bus.btn);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [N-1:0] last_mole;
    int up_len;
    last_mole = '0;
    up_len = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_mole = '0; up_len = 0;
      end else begin
        chk("cyc_mole",      32'(bus.mole),      32'(m_mole));
        chk("cyc_time_left", 32'(bus.time_left), 32'(m_time));
        chk("cyc_score",     32'(bus.score),     32'(m_score));
        chk("cyc_playing",   32'(bus.playing),   32'(m_playing));
        chk("cyc_game_over", 32'(bus.game_over), 32'(m_over));
        chk("cyc_hit",       32'(bus.hit),       32'(m_hit));
        if (!bus.playing && !bus.game_over) last_mole = '0;
        if (bus.mole != '0) begin
          if (up_len == 0 && last_mole != '0) chk("mole_differs", 32'(bus.mole != last_mole), 32'd1);
          up_len++;
          last_mole = bus.mole;
        end else if (up_len != 0) begin
          if (!bus.hit && !bus.game_over) chk("mole_up_len", 32'(up_len), 32'(MOLEC));
          up_len = 0;
        end
        if (bus.game_over) last_mole = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic st, input logic [N-1:0] b);
    bus.start = st;
    bus.btn   = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.btn   = '0;
    cyc_no++;
  endtask

  task automatic start_round();
    cyc_no = -1;
    cyc(1'b1, '0);
  endtask

  task automatic run_to(input int n);
    while (cyc_no < n) cyc(1'b0, '0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mole"},      32'(bus.mole),      32'd0);
    chk({tag, "_time_left"}, 32'(bus.time_left), 32'd0);
    chk({tag, "_score"},     32'(bus.score),     32'd0);
    chk({tag, "_playing"},   32'(bus.playing),   32'd0);
    chk({tag, "_game_over"}, 32'(bus.game_over), 32'd0);
    chk({tag, "_hit"},       32'(bus.hit),       32'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [N-1:0] saved_mole;
    logic [N-1:0] wrong_btn;
    logic [SW-1:0] exp_pen;
    checks = 0; errors = 0; cyc_no = 0;
    bus.start = 1'b0; bus.btn = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    repeat (3) cyc(1'b0, 4'hF);          // presses in IDLE are ignored
    chk("idle_btn_score", 32'(bus.score), 32'd0);

    // Round 1: early hit, then let it run out.
    start_round();
    chk("r1_playing", 32'(bus.playing), 32'd1);
    chk("r1_time",    32'(bus.time_left), 32'd3);
    chk("r1_score",   32'(bus.score), 32'd0);
    cyc(1'b0, '0);
    chk("r1_gap_dark", 32'(bus.mole), 32'd0);
    cyc(1'b0, '0);
    chk("r1_mole_up", 32'($onehot(bus.mole)), 32'd1);
    cyc(1'b0, '0);
    cyc(1'b0, m_mole);                    // 2nd SHOW cycle
    chk("r1_hit",       32'(bus.hit),   32'd1);
    chk("r1_hit_score", 32'(bus.score), 32'd1);
    chk("r1_hit_mole",  32'(bus.mole),  32'd0);
    run_to(29);
    chk("r1_time_last", 32'(bus.time_left), 32'd1);
    chk("r1_not_over",  32'(bus.game_over), 32'd0);
    cyc(1'b0, '0);
    chk("r1_over",      32'(bus.game_over), 32'd1);
    chk("r1_over_time", 32'(bus.time_left), 32'd0);
    chk("r1_over_mole", 32'(bus.mole), 32'd0);
    cyc(1'b0, 4'hF);
    chk("r1_over_btn",  32'(bus.score), 32'd1);

    // Round 2: restart from OVER, 5th-cycle hit, start mid-round, wrong presses, reset mid-SHOW.
    start_round();
    chk("r2_time",  32'(bus.time_left), 32'd3);
    chk("r2_score", 32'(bus.score), 32'd0);
    chk("r2_over",  32'(bus.game_over), 32'd0);
    run_to(6);
    chk("r2_still_up", 32'(bus.mole != '0), 32'd1);
    cyc(1'b0, m_mole);                    // 5th SHOW cycle, same edge as timeout
    chk("r2_hit5",       32'(bus.hit),   32'd1);
    chk("r2_hit5_score", 32'(bus.score), 32'd1);
    cyc(1'b1, '0);                        // start while playing
    chk("r2_mid_start_time",    32'(bus.time_left), 32'd3);
    chk("r2_mid_start_playing", 32'(bus.playing), 32'd1);
    cyc(1'b0, '0);
    saved_mole = m_mole;
    chk("r2_show", 32'(bus.mole != '0), 32'd1);
    wrong_btn = {saved_mole[N-2:0], saved_mole[N-1]};
`ifdef MISS_PENALTY_EN
    exp_pen = '0;
`else
    exp_pen = 8'd1;
`endif
    cyc(1'b0, wrong_btn);
    chk("r2_wrong1_score", 32'(bus.score), 32'(exp_pen));
    chk("r2_wrong1_mole",  32'(bus.mole),  32'(saved_mole));
    chk("r2_wrong1_time",  32'(bus.time_left), 32'd2);
    cyc(1'b0, wrong_btn);
    chk("r2_wrong2_score", 32'(bus.score), 32'(exp_pen));
    #2 reset = 1'b1;
    #1 chk_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;

    // Round 3 from IDLE: hit on first SHOW cycle, press in GAP, hit on the final tick.
    start_round();
    chk("r3_time", 32'(bus.time_left), 32'd3);
    run_to(2);
    cyc(1'b0, m_mole);
    chk("r3_hit1", 32'(bus.score), 32'd1);
    cyc(1'b0, 4'hF);                      // GAP press ignored
    chk("r3_gap_btn", 32'(bus.score), 32'd1);
    run_to(29);
    chk("r3_up_at_end", 32'(bus.mole != '0), 32'd1);
    cyc(1'b0, m_mole);
    chk("r3_final_hit",   32'(bus.hit), 32'd1);
    chk("r3_final_score", 32'(bus.score), 32'd2);
    chk("r3_final_over",  32'(bus.game_over), 32'd1);
    chk("r3_final_time",  32'(bus.time_left), 32'd0);
    chk("r3_final_mole",  32'(bus.mole), 32'd0);
    repeat (3) cyc(1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
